// File: rtl/cache_mem_system.sv
// Hit-rate evaluation block: a wrapping address sequencer drives one read per clock
// into a direct-mapped cache that refills whole lines from a combinational ROM.
module cache_mem_system #(
  parameter int ADDR_W      = 10,
  parameter int LINES       = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_WRAP   = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       Hit,
  output logic [7:0] MemSysOut
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int ROM_W = ADDR_W + 10;

  typedef logic [ADDR_W-1:0] addr_t;

  // Only the low byte of 3*A+7 is kept, so a wide product avoids any overflow concern.
  function automatic logic [7:0] rom_byte(input addr_t a);
    return 8'({10'd0, a} * ROM_W'(3) + ROM_W'(7));
  endfunction

  addr_t             addr_q, addr_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [7:0]        data_q [LINES][BLOCK_BYTES];
  logic              hit_q, hit_d;
  logic [7:0]        dout_q, dout_d;

  logic [OFF_W-1:0]  cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  addr_t             blk_base;
  logic              lookup_hit;
  logic [7:0]        fill_d [BLOCK_BYTES];

  assign cur_off    = addr_q[OFF_W-1:0];
  assign cur_idx    = addr_q[OFF_W +: IDX_W];
  assign cur_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign blk_base   = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

  always_comb begin
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      fill_d[b] = rom_byte(blk_base | addr_t'(b));
    end
    hit_d  = lookup_hit;
    dout_d = lookup_hit ? data_q[cur_idx][cur_off] : rom_byte(addr_q);
    addr_d = (addr_q == addr_t'(ADDR_WRAP - 1)) ? '0 : addr_q + addr_t'(1);
  end

  // Tags and data need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      dout_q  <= 8'd0;
    end else begin
      addr_q <= addr_d;
      hit_q  <= hit_d;
      dout_q <= dout_d;
      if (!lookup_hit) begin
        valid_q[cur_idx] <= 1'b1;
        tag_q[cur_idx]   <= cur_tag;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
          data_q[cur_idx][b] <= fill_d[b];
        end
      end
    end
  end

  assign Hit       = hit_q;
  assign MemSysOut = dout_q;

endmodule

// File: tb/tb_cache_mem_system.sv
// Bench for cache_mem_system: directed hit-rate scenarios plus randomized resets,
// every cycle compared against a block-number-level cache model.
module tb_cache_mem_system;

  localparam int LINES = 8;
  localparam int BB    = 4;
  localparam int WRAP  = 32;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Hit;
  logic [7:0] MemSysOut;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: which memory block each line holds; cached data always equals ROM data.
  bit m_valid [LINES];
  int m_blk   [LINES];
  int m_addr  = 0;
  int e_hit, e_data;

  cache_mem_system dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Hit       (Hit),
    .MemSysOut (MemSysOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rst);
    int blk, ln;
    @(negedge Clk);
    Reset = rst;
    @(posedge Clk);
    #1;
    if (rst) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_addr = 0;
      e_hit  = 0;
      e_data = 0;
    end else begin
      blk    = m_addr / BB;
      ln     = blk % LINES;
      e_hit  = (m_valid[ln] && m_blk[ln] == blk) ? 1 : 0;
      e_data = (3 * m_addr + 7) % 256;
      m_valid[ln] = 1'b1;
      m_blk[ln]   = blk;
      m_addr      = (m_addr + 1) % WRAP;
    end
    chk("model_hit", int'(Hit), e_hit);
    chk("model_data", int'(MemSysOut), e_data);
  endtask

  initial begin
    int hits;
    int misses32;
    int exp_d;

    tick(1'b1);
    chk("reset_hit", int'(Hit), 0);
    chk("reset_data", int'(MemSysOut), 0);

    hits = 0;
    misses32 = 0;
    for (int e = 1; e <= 100; e++) begin
      tick(1'b0);
      hits += int'(Hit);
      if (e == 1) begin
        chk("first_hit", int'(Hit), 0);
        chk("first_data", int'(MemSysOut), 7);
      end
      if (e >= 2 && e <= 4) begin
        exp_d = 7 + 3 * (e - 1);
        chk("blk0_hit", int'(Hit), 1);
        chk("blk0_data", int'(MemSysOut), exp_d);
      end
      if (e <= 32) begin
        if (Hit == 1'b0) misses32++;
        chk("pass1_miss_at_block_start", int'(!Hit), ((e - 1) % BB == 0) ? 1 : 0);
      end
      if (e == 32) begin
        chk("addr31_data", int'(MemSysOut), 100);
        chk("pass1_misses", misses32, 8);
        chk("pass1_hits", hits, 24);
      end
      if (e == 33) chk("wrap_data", int'(MemSysOut), 7);
      if (e >= 33 && e <= 64) chk("pass2_hit", int'(Hit), 1);
      if (e == 100) chk("edge100_data", int'(MemSysOut), 16);
    end
    chk("hits100", hits, 92);

    // Mid-run reset: held reset forces zeros, release restarts a cold cache at 0.
    tick(1'b1);
    for (int e = 1; e <= 40; e++) tick(1'b0);
    tick(1'b1);
    chk("held_rst_hit", int'(Hit), 0);
    chk("held_rst_data", int'(MemSysOut), 0);
    tick(1'b1);
    chk("held_rst_hit2", int'(Hit), 0);
    chk("held_rst_data2", int'(MemSysOut), 0);
    tick(1'b0);
    chk("post_rst_hit", int'(Hit), 0);
    chk("post_rst_data", int'(MemSysOut), 7);

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
